// File: rtl/uart_cmd_decoder.sv
// Host-to-board command decoder: frames A5/CMD/DATA/CHK packets from the UART RX FIFO,
// applies LED / 7-seg updates and answers each packet with an ACK or NAK byte.
module uart_cmd_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk_100MHz,
    input  logic        reset_n,
    input  logic        rx_empty,
    input  logic [7:0]  read_data,
    output logic        read_uart,
    input  logic        tx_full,
    output logic        write_uart,
    output logic [7:0]  write_data,
    output logic [7:0]  led,
    output logic [15:0] digit,
    output logic        cmd_valid,
    output logic [7:0]  err_count
);

    localparam int unsigned    TW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 2);

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;

    typedef enum logic [2:0] {
        IDLE,
        GET_CMD,
        GET_DATA,
        GET_CHK,
        EXEC,
        RESP
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [7:0]      r_cmd;
    logic [7:0]      r_data;
    logic [7:0]      r_led;
    logic [15:0]     r_digit;
    logic [7:0]      r_err;
    logic [7:0]      r_wdata;
    logic            r_cmd_valid;
    logic [TW-1:0]   r_tmo;

    logic            w_in_get;
    logic            w_pop;
    logic            w_tmo_hit;
    logic            w_known;
    logic            w_chk_ok;
    logic            w_err_inc;

    assign w_in_get  = (r_state == GET_CMD) || (r_state == GET_DATA) || (r_state == GET_CHK);
    assign w_pop     = read_uart;
    assign w_tmo_hit = w_in_get && rx_empty && (r_tmo == TMO_LAST);
    assign w_known   = (r_cmd == 8'h01) || (r_cmd[7:2] == 6'b000100) || (r_cmd == 8'h20);
    assign w_chk_ok  = (read_data == (r_cmd ^ r_data));
    assign w_err_inc = w_tmo_hit || ((r_state == EXEC) && !r_cmd_valid);

    // State register
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_pop && (read_data == SYNC_BYTE)) begin
                    w_next = GET_CMD;
                end
            end
            GET_CMD: begin
                if (w_pop) begin
                    w_next = GET_DATA;
                end else if (w_tmo_hit) begin
                    w_next = IDLE;
                end
            end
            GET_DATA: begin
                if (w_pop) begin
                    w_next = GET_CHK;
                end else if (w_tmo_hit) begin
                    w_next = IDLE;
                end
            end
            GET_CHK: begin
                if (w_pop) begin
                    w_next = EXEC;
                end else if (w_tmo_hit) begin
                    w_next = IDLE;
                end
            end
            EXEC: begin
                w_next = RESP;
            end
            RESP: begin
                if (!tx_full) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // FIFO strobes
    always_comb begin
        read_uart  = 1'b0;
        write_uart = 1'b0;
        case (r_state)
            IDLE, GET_CMD, GET_DATA, GET_CHK: read_uart  = !rx_empty;
            RESP:                             write_uart = !tx_full;
            default: begin
                read_uart  = 1'b0;
                write_uart = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_tmo <= '0;
        end else if (w_pop || !w_in_get) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= r_tmo + 1'b1;
        end
    end

    // The verdict is taken as CHK is popped so cmd_valid is already high during EXEC.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_cmd       <= '0;
            r_data      <= '0;
            r_cmd_valid <= 1'b0;
        end else begin
            if (w_pop && (r_state == GET_CMD)) begin
                r_cmd <= read_data;
            end
            if (w_pop && (r_state == GET_DATA)) begin
                r_data <= read_data;
            end
            r_cmd_valid <= w_pop && (r_state == GET_CHK) && w_chk_ok && w_known;
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_led   <= '0;
            r_digit <= '0;
            r_wdata <= '0;
        end else if (r_state == EXEC) begin
            r_wdata <= r_cmd_valid ? ACK_BYTE : NAK_BYTE;
            if (r_cmd_valid) begin
                case (r_cmd)
                    8'h01: r_led <= r_data;
                    8'h10: r_digit[3:0]   <= r_data[3:0];
                    8'h11: r_digit[7:4]   <= r_data[3:0];
                    8'h12: r_digit[11:8]  <= r_data[3:0];
                    8'h13: r_digit[15:12] <= r_data[3:0];
                    8'h20: begin
                        r_led   <= '0;
                        r_digit <= '0;
                    end
                    default: begin
                        r_led   <= r_led;
                        r_digit <= r_digit;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= '0;
        end else if (w_err_inc && (r_err != 8'hFF)) begin
            r_err <= r_err + 8'd1;
        end
    end

    assign write_data = r_wdata;
    assign led        = r_led;
    assign digit      = r_digit;
    assign cmd_valid  = r_cmd_valid;
    assign err_count  = r_err;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Bench for uart_cmd_decoder: queue-modelled RX/TX FIFOs, directed scenarios plus
// random packet streams scored against a packet-level reference model.
module tb_uart_cmd_decoder;

    logic        clk_100MHz = 1'b0;
    logic        reset_n;
    logic        rx_empty;
    logic [7:0]  read_data;
    logic        read_uart;
    logic        tx_full;
    logic        write_uart;
    logic [7:0]  write_data;
    logic [7:0]  led;
    logic [15:0] digit;
    logic        cmd_valid;
    logic [7:0]  err_count;

    uart_cmd_decoder #(.TIMEOUT_CYCLES(16)) dut (
        .clk_100MHz (clk_100MHz),
        .reset_n    (reset_n),
        .rx_empty   (rx_empty),
        .read_data  (read_data),
        .read_uart  (read_uart),
        .tx_full    (tx_full),
        .write_uart (write_uart),
        .write_data (write_data),
        .led        (led),
        .digit      (digit),
        .cmd_valid  (cmd_valid),
        .err_count  (err_count)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    logic [7:0]  rxq[$];
    logic [7:0]  txq[$];
    logic [7:0]  exp_tx[$];
    int unsigned n_pass = 0;
    int unsigned n_chk  = 0;
    int unsigned cv_seen = 0;

    logic [7:0]  m_led;
    logic [3:0]  m_dig[4];
    logic [7:0]  m_err;
    int unsigned m_cv;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic refresh_rx();
        rx_empty  = (rxq.size() == 0);
        read_data = rx_empty ? 8'h00 : rxq[0];
    endtask

    task automatic push(input logic [7:0] b);
        rxq.push_back(b);
        refresh_rx();
    endtask

    task automatic push4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        push(a); push(b); push(c); push(d);
    endtask

    // One clock: sample strobes mid-cycle, apply FIFO effects just after the edge.
    task automatic step();
        logic       p, w;
        logic [7:0] d;
        @(negedge clk_100MHz);
        p = read_uart;
        w = write_uart;
        d = write_data;
        if (cmd_valid === 1'b1) cv_seen++;
        @(posedge clk_100MHz);
        #1;
        if (p && rxq.size() > 0) void'(rxq.pop_front());
        if (w) txq.push_back(d);
        refresh_rx();
    endtask

    task automatic drain(input string tag);
        int unsigned n = 0;
        tx_full = 1'b0;
        while (rxq.size() != 0 && n < 5000) begin
            step();
            n++;
        end
        if (n >= 5000) check({tag, "_drain_bound"}, n, 0);
        repeat (4) step();
    endtask

    task automatic check_tx(input string tag, input logic [7:0] e[$]);
        check({tag, "_tx_count"}, txq.size(), e.size());
        for (int i = 0; i < e.size() && i < txq.size(); i++)
            check($sformatf("%s_tx%0d", tag, i), txq[i], e[i]);
        txq.delete();
    endtask

    task automatic model_run(input logic [7:0] s[$]);
        logic [7:0] b, c, d, k;
        logic       known;
        while (s.size() > 0) begin
            b = s.pop_front();
            if (b != 8'hA5) continue;
            if (s.size() < 3) break;
            c = s.pop_front();
            d = s.pop_front();
            k = s.pop_front();
            known = (c == 8'h01) || (c >= 8'h10 && c <= 8'h13) || (c == 8'h20);
            if (known && ((c ^ d) == k)) begin
                if (c == 8'h01) m_led = d;
                else if (c == 8'h20) begin
                    m_led = 8'h00;
                    for (int j = 0; j < 4; j++) m_dig[j] = 4'h0;
                end else m_dig[c[1:0]] = d[3:0];
                m_cv++;
                exp_tx.push_back(8'h06);
            end else begin
                if (m_err != 8'hFF) m_err = m_err + 8'd1;
                exp_tx.push_back(8'h15);
            end
        end
    endtask

    initial begin
        logic [7:0]  e[$];
        logic [7:0]  stream[$];
        int unsigned cv0, n1, n2, n15;
        logic [7:0]  c, d, k;

        reset_n = 1'b1;
        tx_full = 1'b0;
        refresh_rx();
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk_100MHz);
        #1;
        check("rst_led", led, 8'h00);
        check("rst_digit", digit, 16'h0000);
        check("rst_err", err_count, 8'h00);
        check("rst_wdata", write_data, 8'h00);
        check("rst_cmd_valid", cmd_valid, 1'b0);
        check("rst_read_uart", read_uart, 1'b0);
        check("rst_write_uart", write_uart, 1'b0);
        reset_n = 1'b1;
        step();

        // Good LED command with cycle-exact latency
        cv0 = cv_seen;
        push4(8'hA5, 8'h01, 8'h3C, 8'h3D);
        repeat (4) step();
        check("exec_cmd_valid", cmd_valid, 1'b1);
        check("exec_led_old", led, 8'h00);
        check("exec_write_uart", write_uart, 1'b0);
        step();
        check("resp_write_uart", write_uart, 1'b1);
        check("resp_wdata", write_data, 8'h06);
        check("resp_led", led, 8'h3C);
        check("resp_cmd_valid", cmd_valid, 1'b0);
        drain("led");
        check("led_cv", cv_seen - cv0, 1);
        check("led_err", err_count, 8'h00);
        e = '{8'h06};
        check_tx("led", e);

        push4(8'hA5, 8'h12, 8'h07, 8'h15);
        drain("dig2");
        check("dig2_digit", digit, 16'h0700);
        e = '{8'h06};
        check_tx("dig2", e);

        // Bad checksum and unknown command
        cv0 = cv_seen;
        push4(8'hA5, 8'h01, 8'h3C, 8'h00);
        push4(8'hA5, 8'h7F, 8'h00, 8'h7F);
        drain("nak");
        check("nak_led", led, 8'h3C);
        check("nak_err", err_count, 8'h02);
        check("nak_cv", cv_seen - cv0, 0);
        e = '{8'h15, 8'h15};
        check_tx("nak", e);

        // Garbage before a clear command
        push(8'h00); push(8'hFF); push(8'h5A);
        push4(8'hA5, 8'h20, 8'h00, 8'h20);
        drain("clr");
        check("clr_led", led, 8'h00);
        check("clr_digit", digit, 16'h0000);
        check("clr_err", err_count, 8'h02);
        e = '{8'h06};
        check_tx("clr", e);

        // Inter-byte timeout: 15 empty cycles abandon the packet
        push(8'hA5); push(8'h01);
        repeat (2) step();
        repeat (14) step();
        check("tmo_before", err_count, 8'h02);
        step();
        check("tmo_after", err_count, 8'h03);
        push4(8'hA5, 8'h01, 8'h55, 8'h54);
        drain("tmo");
        check("tmo_led", led, 8'h55);
        e = '{8'h06};
        check_tx("tmo", e);

        // TX back-pressure with a second packet queued
        tx_full = 1'b1;
        push4(8'hA5, 8'h01, 8'h11, 8'h10);
        push4(8'hA5, 8'h01, 8'h22, 8'h23);
        repeat (5) step();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall_wu%0d", i), write_uart, 1'b0);
            check($sformatf("stall_ru%0d", i), read_uart, 1'b0);
            step();
        end
        check("stall_rxq", rxq.size(), 4);
        tx_full = 1'b0;
        #1;
        check("release_wu", write_uart, 1'b1);
        check("release_wdata", write_data, 8'h06);
        drain("stall");
        check("stall_led", led, 8'h22);
        e = '{8'h06, 8'h06};
        check_tx("stall", e);

        // Random packet stream against the reference model
        m_led = 8'h22;
        for (int j = 0; j < 4; j++) m_dig[j] = 4'h0;
        m_err = 8'h03;
        m_cv  = 0;
        cv0   = cv_seen;
        exp_tx.delete();
        stream.delete();
        for (int p = 0; p < 40; p++) begin
            for (int g = 0; g < $urandom_range(0, 2); g++) begin
                d = 8'($urandom_range(0, 255));
                if (d == 8'hA5) d = 8'h00;
                stream.push_back(d);
            end
            case ($urandom_range(0, 5))
                0: c = 8'h01;
                1: c = 8'h20;
                2: c = 8'($urandom_range(0, 255));
                default: c = 8'h10 + 8'($urandom_range(0, 3));
            endcase
            d = 8'($urandom_range(0, 255));
            k = c ^ d;
            if ($urandom_range(0, 4) == 0) k = k ^ 8'($urandom_range(1, 255));
            stream.push_back(8'hA5);
            stream.push_back(c);
            stream.push_back(d);
            stream.push_back(k);
        end
        model_run(stream);
        foreach (stream[i]) begin
            push(stream[i]);
            for (int g = 0; g < $urandom_range(0, 2); g++) begin
                tx_full = ($urandom_range(0, 3) == 0);
                step();
            end
        end
        drain("rnd");
        check("rnd_led", led, m_led);
        check("rnd_digit", digit, {m_dig[3], m_dig[2], m_dig[1], m_dig[0]});
        check("rnd_err", err_count, m_err);
        check("rnd_cv", cv_seen - cv0, m_cv);
        check_tx("rnd", exp_tx);

        // Saturation of the error counter
        n1 = 254 - m_err;
        n2 = 256 - n1;
        for (int i = 0; i < n1; i++) push4(8'hA5, 8'h7F, 8'h00, 8'h7F);
        drain("sat1");
        check("sat_254", err_count, 8'd254);
        for (int i = 0; i < n2; i++) push4(8'hA5, 8'h7F, 8'h00, 8'h7F);
        drain("sat2");
        check("sat_255", err_count, 8'd255);
        n15 = 0;
        foreach (txq[i]) if (txq[i] == 8'h15) n15++;
        check("sat_nak_count", n15, 256);
        check("sat_tx_count", txq.size(), 256);
        txq.delete();

        // Reset in the middle of a packet
        push4(8'hA5, 8'h01, 8'h77, 8'h76);
        repeat (2) step();
        reset_n = 1'b0;
        rxq.delete();
        refresh_rx();
        #1;
        check("mid_rst_led", led, 8'h00);
        check("mid_rst_digit", digit, 16'h0000);
        check("mid_rst_err", err_count, 8'h00);
        check("mid_rst_wdata", write_data, 8'h00);
        check("mid_rst_cv", cmd_valid, 1'b0);
        check("mid_rst_ru", read_uart, 1'b0);
        check("mid_rst_wu", write_uart, 1'b0);
        repeat (2) @(posedge clk_100MHz);
        #1 reset_n = 1'b1;
        repeat (10) step();
        check("mid_rst_no_tx", txq.size(), 0);
        push4(8'hA5, 8'h13, 8'h0B, 8'h18);
        drain("post_rst");
        check("post_rst_digit", digit, 16'hB000);
        e = '{8'h06};
        check_tx("post_rst", e);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
